// File: rtl/axi_slv_ram.sv
// AXI4 slave backed by a 32-bit word register-array memory.
// Services one burst at a time; write and read requests are arbitrated round-robin.
`timescale 1ns/1ps
module axi_slv_ram #(
    parameter int unsigned P_DEPTH_LOG2 = 10
) (
    input  logic        aclk,
    input  logic        rstn,
    input  logic [15:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [15:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);
    localparam int unsigned AW = P_DEPTH_LOG2;
    localparam logic [16:0] MEM_BYTES = 17'(4 * (2 ** P_DEPTH_LOG2));

    typedef enum logic [1:0] {StIdle, StWrData, StWrResp, StRdData} state_e;

    state_e      state_q;
    logic        last_rd_q;  // last grant went to read
    logic [15:0] addr_q;     // address of the current beat
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [7:0]  cnt_q;
    logic [1:0]  err_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q;

    logic [31:0] mem [2 ** P_DEPTH_LOG2];

    logic        grant_wr, grant_rd;
    logic [15:0] addr_nxt;
    logic [1:0]  wr_resp, wr_err;
    logic        wr_last, wr_en;
    logic [15:0] rd_addr;
    logic [1:0]  rd_resp;
    logic [31:0] rd_word;

    function automatic logic [1:0] beat_resp(logic [15:0] addr, logic [2:0] size,
                                             logic [1:0] burst);
        if ({1'b0, addr} >= MEM_BYTES) return 2'b11;
        else if (size != 3'b010 || burst[1]) return 2'b10;
        else return 2'b00;
    endfunction

    function automatic logic [1:0] max_resp(logic [1:0] a, logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Ties go to the channel that did not win last time.
    assign grant_wr = rstn && (state_q == StIdle) && s_axi_awvalid &&
                      (!s_axi_arvalid || last_rd_q);
    assign grant_rd = rstn && (state_q == StIdle) && s_axi_arvalid &&
                      (!s_axi_awvalid || !last_rd_q);

    assign addr_nxt = (burst_q == 2'b00) ? addr_q : addr_q + 16'd4;

    assign wr_resp = beat_resp(addr_q, size_q, burst_q);
    assign wr_last = (cnt_q == len_q);
    // A wlast that disagrees with the beat count only affects the response.
    assign wr_err  = max_resp(max_resp(err_q, wr_resp),
                              (s_axi_wlast != wr_last) ? 2'b10 : 2'b00);
    assign wr_en   = (state_q == StWrData) && s_axi_wvalid && (wr_resp == 2'b00);

    // Select the address of the read beat to be registered next.
    always_comb begin
        rd_addr = addr_nxt;
        rd_resp = beat_resp(addr_nxt, size_q, burst_q);
        if (state_q == StIdle) begin
            rd_addr = s_axi_araddr;
            rd_resp = beat_resp(s_axi_araddr, s_axi_arsize, s_axi_arburst);
        end
    end

    assign rd_word = mem[rd_addr[AW+1:2]];

    // Transaction FSM with registered B and R channel outputs.
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            last_rd_q <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_wr) begin
                        last_rd_q <= 1'b0;
                        addr_q    <= s_axi_awaddr;
                        len_q     <= s_axi_awlen;
                        size_q    <= s_axi_awsize;
                        burst_q   <= s_axi_awburst;
                        cnt_q     <= '0;
                        err_q     <= '0;
                        state_q   <= StWrData;
                    end else if (grant_rd) begin
                        last_rd_q <= 1'b1;
                        addr_q    <= s_axi_araddr;
                        len_q     <= s_axi_arlen;
                        size_q    <= s_axi_arsize;
                        burst_q   <= s_axi_arburst;
                        cnt_q     <= '0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= (rd_resp == 2'b00) ? rd_word : 32'd0;
                        rresp_q   <= rd_resp;
                        rlast_q   <= (s_axi_arlen == 8'd0);
                        state_q   <= StRdData;
                    end
                end
                StWrData: begin
                    if (s_axi_wvalid) begin
                        cnt_q  <= cnt_q + 8'd1;
                        addr_q <= addr_nxt;
                        err_q  <= wr_err;
                        if (wr_last) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= wr_err;
                            state_q  <= StWrResp;
                        end
                    end
                end
                StWrResp: begin
                    if (s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StRdData: begin
                    if (s_axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            addr_q  <= addr_nxt;
                            cnt_q   <= cnt_q + 8'd1;
                            rdata_q <= (rd_resp == 2'b00) ? rd_word : 32'd0;
                            rresp_q <= rd_resp;
                            rlast_q <= (cnt_q + 8'd1 == len_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Byte-enabled memory write; contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi_awready = grant_wr;
    assign s_axi_arready = grant_rd;
    assign s_axi_wready  = (state_q == StWrData);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_slv_ram.sv
// Scoreboard bench for axi_slv_ram: drivers push expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
`timescale 1ns/1ps
module tb_axi_slv_ram;
    localparam int BOUND = 200;

    logic        aclk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst;
    logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    always #5 aclk = ~aclk;

    axi_slv_ram #(.P_DEPTH_LOG2(10)) dut (
        .aclk(aclk), .rstn(rstn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    logic [1:0]  bq[$];
    rbeat_t      rq[$];
    int          r_cyc[$];
    bit          gq[$];   // grant order, 1 = write
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] wd[16];
    logic [3:0]  ws[16];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles", name, BOUND);
    endtask

    // Monitor: scoreboard pops, grant order and stall-hold checks.
    initial begin : monitor
        rbeat_t e;
        rbeat_t held;
        bit     stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (!rstn) begin
                stalled = 1'b0;
            end else begin
                if (s_axi_awvalid && s_axi_arvalid)
                    chk("ready_exclusive", 32'(s_axi_awready && s_axi_arready), 32'd0);
                if (s_axi_awvalid && s_axi_awready) gq.push_back(1'b1);
                if (s_axi_arvalid && s_axi_arready) gq.push_back(1'b0);
                if (s_axi_bvalid && s_axi_bready) begin
                    if (bq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_b: got bresp %0d, expected no response",
                                 s_axi_bresp);
                    end else begin
                        chk("bresp", 32'(s_axi_bresp), 32'(bq.pop_front()));
                    end
                end
                if (s_axi_rvalid && stalled) begin
                    chk("r_hold_data", s_axi_rdata, held.data);
                    chk("r_hold_ctl", 32'({s_axi_rresp, s_axi_rlast}), 32'({held.resp, held.last}));
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    if (rq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_r: got rdata 0x%08h, expected no beat",
                                 s_axi_rdata);
                    end else begin
                        e = rq.pop_front();
                        chk("rdata", s_axi_rdata, e.data);
                        chk("rresp", 32'(s_axi_rresp), 32'(e.resp));
                        chk("rlast", 32'(s_axi_rlast), 32'(e.last));
                        r_cyc.push_back(cyc);
                    end
                end
                stalled = s_axi_rvalid && !s_axi_rready;
                held = '{data: s_axi_rdata, resp: s_axi_rresp, last: s_axi_rlast};
            end
        end
    end

    task automatic send_aw(input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input logic [1:0] bu);
        int n = 0;
        s_axi_awaddr = a; s_axi_awlen = l; s_axi_awsize = sz; s_axi_awburst = bu;
        s_axi_awvalid = 1'b1;
        @(negedge aclk);
        while (!s_axi_awready && n < BOUND) begin @(negedge aclk); n++; end
        if (!s_axi_awready) timeout("aw_handshake");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input logic [1:0] bu);
        int n = 0;
        s_axi_araddr = a; s_axi_arlen = l; s_axi_arsize = sz; s_axi_arburst = bu;
        s_axi_arvalid = 1'b1;
        @(negedge aclk);
        while (!s_axi_arready && n < BOUND) begin @(negedge aclk); n++; end
        if (!s_axi_arready) timeout("ar_handshake");
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        @(negedge aclk);
        while (!s_axi_wready && n < BOUND) begin @(negedge aclk); n++; end
        if (!s_axi_wready) timeout("w_handshake");
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    // bad_last < 0: wlast on the final beat; otherwise wlast only on beat bad_last.
    task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz,
                            input logic [1:0] bu, input int bad_last, input logic [1:0] exp_b);
        int n = 0;
        bq.push_back(exp_b);
        send_aw(a, l, sz, bu);
        for (int i = 0; i <= int'(l); i++)
            send_w(wd[i], ws[i], (bad_last < 0) ? (i == int'(l)) : (i == bad_last));
        do begin @(posedge aclk); n++; end while (bq.size() != 0 && n < BOUND);
        if (bq.size() != 0) begin timeout("b_response"); bq.delete(); end
        #1;
    endtask

    task automatic write1(input logic [15:0] a, input logic [31:0] d);
        wd[0] = d; ws[0] = 4'hF;
        do_write(a, 8'd0, 3'b010, 2'b01, -1, 2'b00);
    endtask

    task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rq.push_back('{data: d, resp: resp, last: last});
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input logic [1:0] bu, input bit chk_lat);
        int n = 0;
        send_ar(a, l, sz, bu);
        if (chk_lat) chk("r_latency", 32'(s_axi_rvalid), 32'd1);
        do begin @(posedge aclk); n++; end while (rq.size() != 0 && n < BOUND);
        if (rq.size() != 0) begin timeout("r_beats"); rq.delete(); end
        #1;
    endtask

    task automatic chk_grants(input bit first, input bit second);
        chk("grant_count", 32'(gq.size()), 32'd2);
        if (gq.size() == 2) begin
            chk("grant_first", 32'(gq[0]), 32'(first));
            chk("grant_second", 32'(gq[1]), 32'(second));
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        // Requests held during reset must not be acknowledged.
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_wready", 32'(s_axi_wready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
        chk("rst_rlast", 32'(s_axi_rlast), 32'd0);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        rstn = 1'b1;
        @(posedge aclk); #1;

        // Single write then read back with latency check.
        write1(16'h0010, 32'hDEADBEEF);
        exp_r(32'hDEADBEEF, 2'b00, 1'b1);
        do_read(16'h0010, 8'd0, 3'b010, 2'b01, 1'b1);

        // INCR burst with partial strobe over a preloaded region.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hFFFFFFFF; ws[i] = 4'hF; end
        do_write(16'h0100, 8'd3, 3'b010, 2'b01, -1, 2'b00);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        ws[1] = 4'b0011;
        do_write(16'h0100, 8'd3, 3'b010, 2'b01, -1, 2'b00);
        exp_r(32'h00000001, 2'b00, 1'b0);
        exp_r(32'hFFFF0002, 2'b00, 1'b0);
        exp_r(32'h00000003, 2'b00, 1'b0);
        exp_r(32'h00000004, 2'b00, 1'b1);
        r_cyc.delete();
        do_read(16'h0100, 8'd3, 3'b010, 2'b01, 1'b0);
        chk("r_beat_count", 32'(r_cyc.size()), 32'd4);
        if (r_cyc.size() == 4) chk("r_back_to_back", 32'(r_cyc[3] - r_cyc[0]), 32'd3);

        // Out-of-range accesses.
        write1(16'h0000, 32'h0BADF00D);
        write1(16'h0FF8, 32'h11111111);
        wd[0] = 32'hA5A5A5A5; ws[0] = 4'hF;
        wd[1] = 32'h5A5A5A5A; ws[1] = 4'hF;
        do_write(16'h0FFC, 8'd1, 3'b010, 2'b01, -1, 2'b11);
        exp_r(32'h11111111, 2'b00, 1'b0);
        exp_r(32'hA5A5A5A5, 2'b00, 1'b1);
        do_read(16'h0FF8, 8'd1, 3'b010, 2'b01, 1'b0);
        exp_r(32'h0BADF00D, 2'b00, 1'b1);
        do_read(16'h0000, 8'd0, 3'b010, 2'b01, 1'b0);
        exp_r(32'h0, 2'b11, 1'b0);
        exp_r(32'h0, 2'b11, 1'b1);
        do_read(16'h1000, 8'd1, 3'b010, 2'b01, 1'b0);

        // Contention: last grant was a read, so write wins, then read.
        gq.delete();
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        exp_r(32'h12345678, 2'b00, 1'b1);
        fork
            do_write(16'h0200, 8'd0, 3'b010, 2'b01, -1, 2'b00);
            do_read(16'h0200, 8'd0, 3'b010, 2'b01, 1'b0);
        join
        chk_grants(1'b1, 1'b0);
        // After a lone write, contention must favour read.
        write1(16'h0204, 32'h55AA55AA);
        gq.delete();
        wd[0] = 32'h00000077; ws[0] = 4'hF;
        exp_r(32'h55AA55AA, 2'b00, 1'b1);
        fork
            do_write(16'h0208, 8'd0, 3'b010, 2'b01, -1, 2'b00);
            do_read(16'h0204, 8'd0, 3'b010, 2'b01, 1'b0);
        join
        chk_grants(1'b0, 1'b1);

        // Protocol errors.
        for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 7); ws[i] = 4'hF; end
        do_write(16'h0300, 8'd2, 3'b010, 2'b01, 0, 2'b10);
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(16'h0010, 8'd0, 3'b001, 2'b01, -1, 2'b10);
        exp_r(32'hDEADBEEF, 2'b00, 1'b1);
        do_read(16'h0010, 8'd0, 3'b010, 2'b01, 1'b0);
        exp_r(32'h0, 2'b10, 1'b1);
        do_read(16'h0010, 8'd0, 3'b001, 2'b01, 1'b0);
        exp_r(32'h0, 2'b10, 1'b1);
        do_read(16'h0010, 8'd0, 3'b010, 2'b10, 1'b0);

        // FIXED read with rready toggling.
        write1(16'h0020, 32'hCAFE0020);
        for (int i = 0; i < 8; i++) exp_r(32'hCAFE0020, 2'b00, i == 7);
        fork
            do_read(16'h0020, 8'd7, 3'b010, 2'b00, 1'b0);
            begin : toggler
                int k;
                k = 0;
                while (rq.size() != 0 && k < BOUND) begin
                    @(posedge aclk); #1;
                    s_axi_rready = !s_axi_rready;
                    k++;
                end
                s_axi_rready = 1'b1;
            end
        join
        s_axi_rready = 1'b1;

        // Reset in the middle of a FIXED burst.
        for (int i = 0; i < 8; i++) exp_r(32'hCAFE0020, 2'b00, i == 7);
        send_ar(16'h0020, 8'd7, 3'b010, 2'b00);
        n = 0;
        while (rq.size() > 6 && n < BOUND) begin @(posedge aclk); #1; n++; end
        if (rq.size() > 6) timeout("mid_burst");
        chk("mid_burst_rvalid", 32'(s_axi_rvalid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("async_rst_rlast", 32'(s_axi_rlast), 32'd0);
        rq.delete();
        repeat (2) @(posedge aclk);
        #1;
        rstn = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        // Back in idle with grant history reset: write wins, memory retained.
        gq.delete();
        wd[0] = 32'h0000BEEF; ws[0] = 4'hF;
        exp_r(32'hDEADBEEF, 2'b00, 1'b1);
        fork
            do_write(16'h0024, 8'd0, 3'b010, 2'b01, -1, 2'b00);
            do_read(16'h0010, 8'd0, 3'b010, 2'b01, 1'b0);
        join
        chk_grants(1'b1, 1'b0);

        repeat (3) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_slv_ram.md
Name: axi_slv_ram

Overview:
- AXI4 slave (responder) with an internal 32-bit-word register-array memory.
- It is the far end of the UART-to-AXI master bridge: it services the bridge's AW/W/B and AR/R bursts for bring-up, loopback and regression benches.
- Handles one transaction at a time, with round-robin arbitration between write and read.

Parameters:
P_DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB, byte addresses 0x0000-0x0FFF)

Ports:
aclk  in  1  clock
rstn  in  1  asynchronous, active-low reset
s_axi_awaddr  in  16  write start byte address
s_axi_awlen  in  8  write beats minus 1
s_axi_awsize  in  3  beat size; only 3'b010 legal
s_axi_awburst  in  2  burst type
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  16  read start byte address
s_axi_arlen  in  8  read beats minus 1
s_axi_arsize  in  3  beat size; only 3'b010 legal
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs 0; last-grant = read (so write wins first). Memory contents are not reset. Reset mid-burst abandons the burst immediately.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE arbitration:
  - Only awvalid high: grant write. Only arvalid high: grant read.
  - Both high: grant the opposite of last-grant.
  - awready/arready are combinational, high only in IDLE for the granted channel. Never both high in the same cycle.
- AW accept: latch addr, len, size, burst. Clear beat counter and error latch. Go to WR_DATA.
- WR_DATA:
  - wready = 1.
  - Each wvalid&&wready beat writes mem[addr[P_DEPTH_LOG2+1:2]] byte-wise per wstrb, but only if the beat resp is OKAY.
  - Beat counter increments. The beat where count == len ends the phase and moves to WR_RESP. wready drops the next cycle.
  - If wlast != (count == len) on any beat, record SLVERR. The beat count, not wlast, terminates the phase.
- WR_RESP: bvalid = 1 and bresp = accumulated response, held until bready. Then go to IDLE with bvalid = 0 the next cycle.
- AR accept: latch fields and move to RD_DATA.
  - rvalid = 1, rdata/rresp/rlast for beat 0 appear the cycle after the AR handshake (latency 1).
  - On each rvalid&&rready, the next beat is registered the following cycle, giving back-to-back one beat per cycle while rready stays high.
  - rvalid/rdata/rresp/rlast are held stable while rready is low.
  - After the beat with rlast = 1 handshakes, go to IDLE with rvalid = 0.
- Address sequencing:
  - FIXED (2'b00): address constant.
  - INCR (2'b01): +4 per beat, 16-bit wrap-around (0xFFFC to 0x0000).
- Per-beat response:
  - DECERR (2'b11) if addr >= 4*2^P_DEPTH_LOG2.
  - Else SLVERR (2'b10) if size != 3'b010 or burst is WRAP/reserved (2'b10/2'b11).
  - Else OKAY.
  - An errored write beat does not modify memory. An errored read beat returns rdata = 0.
- bresp accumulation is the numeric maximum over all beats and the wlast-mismatch flag (DECERR > SLVERR > OKAY).
- Each rresp is per beat.
- Address byte lanes addr[1:0] are ignored; access is word-aligned.
- Simultaneous events: a new AW/AR is never accepted outside IDLE. A valid arriving on the non-granted channel stays pending, and the master must hold it per AXI.
- last-grant updates on each AW/AR handshake.

Test Plan:
- Single write, AW 0x0010 len 0 data 0xDEADBEEF strb 4'hF, then single read of 0x0010 -> bresp 00; rdata 0xDEADBEEF, rresp 00, rlast 1; rvalid one cycle after AR handshake.
- INCR write, 4 beats at 0x0100 with data 1..4, strb 4'b0011 on beat 2; memory preloaded 0xFFFFFFFF; INCR read, len 3, rready always high -> rdata 1, 0xFFFF0002, 3, 4 on consecutive cycles; rlast only on beat 4.
- Read to 0x1000, len 1 -> two beats, rresp 11, rdata 0. Write to 0x0FFC, len 1 -> bresp 11, word 0x3FF written, nothing else changed.
- awvalid and arvalid raised in the same cycle, both held through two back-to-back requests -> write granted first, read second; awready and arready never high together.
- wlast asserted on beat 1 of a len=2 write -> three beats still accepted, bresp 10. awsize 3'b001 -> bresp 10, memory unchanged.
- rready toggled 1/0 during an 8-beat FIXED read of 0x0020 -> every beat reads mem[8] with output held while stalled. Then rstn pulsed low mid-burst -> rvalid 0 asynchronously and FSM returns to IDLE.
